// File: rtl/fcmp_unit.sv
// fcmp_unit: two-stage floating-point compare/select stage (feq/flt/fle/fmin/fmax)
// with a valid/ready handshake on both sides and full-throughput backpressure.
module fcmp_unit #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_flag_op
);
    logic             s1_valid;
    logic [2:0]       s1_op;
    logic [31:0]      s1_a, s1_b;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_move, both_zero, sign_diff, fless, lt, eq, flag;
    logic [31:0]      res;

    assign s2_move  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ~s1_valid | s2_move;

    always_comb begin
        both_zero = (s1_a[30:0] == 31'd0) && (s1_b[30:0] == 31'd0);
        sign_diff = s1_a[31] ^ s1_b[31];
        // sign-magnitude ordering: negatives compare with magnitudes reversed
        fless = sign_diff ? s1_a[31] :
                s1_a[31] ? (s1_b[30:0] < s1_a[30:0]) : (s1_a[30:0] < s1_b[30:0]);
        lt = fless & ~both_zero;
        eq = (s1_a == s1_b) | both_zero;
        flag = (s1_op != 3'd3) && (s1_op != 3'd4);
        res = (s1_op == 3'd0) ? {31'b0, eq} :
              (s1_op == 3'd1) ? {31'b0, lt} :
              (s1_op == 3'd2) ? {31'b0, lt | eq} :
              (s1_op == 3'd3) ? ((both_zero && sign_diff) ? 32'h8000_0000 : (lt ? s1_a : s1_b)) :
              (s1_op == 3'd4) ? ((both_zero && sign_diff) ? 32'h0000_0000 : (lt ? s1_b : s1_a)) :
              32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= 32'd0;
            out_tag     <= '0;
            out_flag_op <= 1'b0;
        end else begin
            if (in_valid && in_ready)
                s1_valid <= 1'b1;
            else if (s2_move)
                s1_valid <= 1'b0;
            if (s2_move) begin
                out_valid   <= 1'b1;
                out_data    <= res;
                out_tag     <= s1_tag;
                out_flag_op <= flag;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_op  <= in_op;
            s1_a   <= in_a;
            s1_b   <= in_b;
            s1_tag <= in_tag;
        end
    end
endmodule
